csr_unit: RTL and testbench

Machine-mode CSR execution unit for the multi-cycle core. It accepts one decoded Zicsr instruction at a time from the decode/register-read stage and performs the atomic read-modify-write on its CSR set. It returns the old CSR value to writeback and keeps the 64-bit cycle and instret counters that back the `cycle`/`instret` user views.

---
 rtl/csr_unit.sv | 170 +++++++++++++++++
 tb/tb_csr_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// Machine-mode Zicsr execution unit: one CSR read-modify-write per request through
// IDLE/READ/WRITE/RESP, plus the free-running 64-bit mcycle and minstret counters.
module csr_unit #(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  funct3,
   input  logic [11:0] csr_adr,
   input  logic [31:0] rs1_val,
   input  logic [4:0]  rs1_idx,
   input  logic        retire,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_illegal
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam logic [31:0] ALIGN4 = 32'hFFFF_FFFC;

   logic [1:0]  state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [11:0] adr_q, adr_d;
   logic [31:0] opnd_q, opnd_d;
   logic [4:0]  idx_q, idx_d;
   logic [31:0] old_q, old_d;
   logic        ill_q, ill_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic [63:0] mcycle_q, mcycle_d;
   logic [63:0] minstret_q, minstret_d;

   logic [31:0] rd_val;
   logic        mapped;
   logic        wants_wr;
   logic        rd_ill;
   logic        wr_en;
   logic [31:0] wr_val;

   // The 0xCxx user views alias the machine counters and are read-only.
   always_comb begin
      rd_val = '0;
      mapped = 1'b1;
      case (adr_q)
         12'h305:          rd_val = mtvec_q;
         12'h340:          rd_val = mscratch_q;
         12'h341:          rd_val = mepc_q;
         12'h342:          rd_val = mcause_q;
         12'hB00, 12'hC00: rd_val = mcycle_q[31:0];
         12'hB80, 12'hC80: rd_val = mcycle_q[63:32];
         12'hB02, 12'hC02: rd_val = minstret_q[31:0];
         12'hB82, 12'hC82: rd_val = minstret_q[63:32];
         default:          mapped = 1'b0;
      endcase
      wants_wr = (op_q == 2'b01) || (idx_q != 5'd0);
      rd_ill   = !mapped || (op_q == 2'b00) || (wants_wr && (adr_q[11:8] == 4'hC));
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      adr_d      = adr_q;
      opnd_d     = opnd_q;
      idx_d      = idx_q;
      old_d      = old_q;
      ill_d      = ill_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      wr_en      = 1'b0;

      case (op_q)
         2'b01:   wr_val = opnd_q;
         2'b10:   wr_val = old_q | opnd_q;
         default: wr_val = old_q & ~opnd_q;
      endcase

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op_d    = funct3[1:0];
               adr_d   = csr_adr;
               opnd_d  = funct3[2] ? {27'b0, rs1_idx} : rs1_val;
               idx_d   = rs1_idx;
               state_d = S_READ;
            end
         end
         S_READ: begin
            ill_d   = rd_ill;
            old_d   = rd_ill ? 32'h0 : rd_val;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            wr_en   = !ill_q && wants_wr;
            state_d = S_RESP;
         end
         default: begin
            if (rsp_ready) state_d = S_IDLE;
         end
      endcase

      if (wr_en) begin
         case (adr_q)
            12'h305: mtvec_d    = wr_val & ALIGN4;
            12'h340: mscratch_d = wr_val;
            12'h341: mepc_d     = wr_val & ALIGN4;
            12'h342: mcause_d   = wr_val;
            default: ;
         endcase
      end

      // A software write to a counter half suppresses that cycle's increment.
      if (wr_en && adr_q == 12'hB00)      mcycle_d = {mcycle_q[63:32], wr_val};
      else if (wr_en && adr_q == 12'hB80) mcycle_d = {wr_val, mcycle_q[31:0]};
      else                                mcycle_d = mcycle_q + 64'd1;

      if (wr_en && adr_q == 12'hB02)      minstret_d = {minstret_q[63:32], wr_val};
      else if (wr_en && adr_q == 12'hB82) minstret_d = {wr_val, minstret_q[31:0]};
      else if (retire)                    minstret_d = minstret_q + 64'd1;
      else                                minstret_d = minstret_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         op_q       <= 2'b00;
         adr_q      <= '0;
         opnd_q     <= '0;
         idx_q      <= '0;
         old_q      <= '0;
         ill_q      <= 1'b0;
         mtvec_q    <= MTVEC_RESET & ALIGN4;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         adr_q      <= adr_d;
         opnd_q     <= opnd_d;
         idx_q      <= idx_d;
         old_q      <= old_d;
         ill_q      <= ill_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end

   assign req_ready   = (state_q == S_IDLE);
   assign rsp_valid   = (state_q == S_RESP);
   assign rsp_data    = rsp_valid ? old_q : 32'h0;
   assign rsp_illegal = rsp_valid & ill_q;

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: a vector table for single CSR operations plus
// hand-written sequences for reset, counters, retire collision and backpressure.
module tb_csr_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  funct3 = 3'b0;
   logic [11:0] csr_adr = 12'h0;
   logic [31:0] rs1_val = 32'h0;
   logic [4:0]  rs1_idx = 5'd0;
   logic        retire = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_data;
   logic        rsp_illegal;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   csr_unit #(.MTVEC_RESET(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .funct3(funct3), .csr_adr(csr_adr), .rs1_val(rs1_val), .rs1_idx(rs1_idx),
      .retire(retire), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_illegal(rsp_illegal)
   );

   typedef struct {
      logic [2:0]  f3;
      logic [11:0] adr;
      logic [31:0] val;
      logic [4:0]  idx;
      logic        chk;
      logic [31:0] exp_d;
      logic        exp_i;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs[NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] f3, input logic [11:0] adr,
                        input logic [31:0] val, input logic [4:0] idx);
      funct3  = f3;
      csr_adr = adr;
      rs1_val = val;
      rs1_idx = idx;
   endtask

   task automatic wait_rsp(output logic [31:0] d, output logic il);
      logic got;
      got = 1'b0;
      d   = '0;
      il  = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            got = 1'b1;
            d   = rsp_data;
            il  = rsp_illegal;
         end
      end
      if (!got) begin
         n_tests++;
         n_fail++;
         $display("FAIL rsp_timeout: got rsp_valid=0 expected rsp_valid=1");
      end
   endtask

   task automatic do_op(input logic [2:0] f3, input logic [11:0] adr,
                        input logic [31:0] val, input logic [4:0] idx,
                        output logic [31:0] d, output logic il);
      @(negedge clk);
      drive(f3, adr, val, idx);
      req_valid = 1'b1;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_rsp(d, il);
      @(posedge clk);
      #1;
   endtask

   // Reset, then read mcycle back-to-back: accepts 4 cycles apart give 1 and 5.
   task automatic rst_count(input string tag);
      logic [31:0] d1, d2;
      logic        i1, i2;
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      #1;
      check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
      check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
      check({tag, "_rsp_data"}, rsp_data, 32'd0);
      check({tag, "_rsp_illegal"}, {31'b0, rsp_illegal}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      drive(3'b010, 12'hB00, 32'h0, 5'd0);
      req_valid = 1'b1;
      rst_n     = 1'b1;
      wait_rsp(d1, i1);
      wait_rsp(d2, i2);
      req_valid = 1'b0;
      check({tag, "_mcycle_first"}, d1, 32'd1);
      check({tag, "_mcycle_second"}, d2, 32'd5);
      @(posedge clk);
      #1;
   endtask

   logic [31:0] d;
   logic        il;

   initial begin
      vecs[0]  = '{3'b001, 12'h340, 32'hDEADBEEF, 5'd1,  1'b1, 32'h0000_0000, 1'b0};
      vecs[1]  = '{3'b010, 12'h340, 32'h0000_00F0, 5'd1, 1'b1, 32'hDEADBEEF, 1'b0};
      vecs[2]  = '{3'b011, 12'h340, 32'hFFFF_0000, 5'd1, 1'b1, 32'hDEADBEFF, 1'b0};
      vecs[3]  = '{3'b010, 12'h340, 32'h0,         5'd0, 1'b1, 32'h0000_BEFF, 1'b0};
      vecs[4]  = '{3'b110, 12'hC00, 32'h0,         5'd0, 1'b0, 32'h0,         1'b0};
      vecs[5]  = '{3'b001, 12'hC00, 32'h5,         5'd1, 1'b1, 32'h0,         1'b1};
      vecs[6]  = '{3'b010, 12'h7FF, 32'h0,         5'd0, 1'b1, 32'h0,         1'b1};
      vecs[7]  = '{3'b001, 12'h341, 32'h0000_1003, 5'd3, 1'b1, 32'h0,         1'b0};
      vecs[8]  = '{3'b010, 12'h341, 32'h0,         5'd0, 1'b1, 32'h0000_1000, 1'b0};
      vecs[9]  = '{3'b000, 12'h340, 32'hFFFF_FFFF, 5'd1, 1'b1, 32'h0,         1'b1};
      vecs[10] = '{3'b100, 12'h340, 32'hFFFF_FFFF, 5'd1, 1'b1, 32'h0,         1'b1};
      vecs[11] = '{3'b010, 12'h340, 32'h0,         5'd0, 1'b1, 32'h0000_BEFF, 1'b0};
      vecs[12] = '{3'b101, 12'h305, 32'hFFFF_FFFF, 5'd5, 1'b1, 32'h0,         1'b0};
      vecs[13] = '{3'b110, 12'h305, 32'h0,         5'h1B, 1'b1, 32'h4,        1'b0};
      vecs[14] = '{3'b111, 12'h305, 32'h0,         5'h0C, 1'b1, 32'h1C,       1'b0};
      vecs[15] = '{3'b010, 12'h305, 32'h0,         5'd0, 1'b1, 32'h10,        1'b0};
      vecs[16] = '{3'b001, 12'h342, 32'h8000_000B, 5'd1, 1'b1, 32'h0,         1'b0};
      vecs[17] = '{3'b010, 12'h342, 32'h0,         5'd0, 1'b1, 32'h8000_000B, 1'b0};
      vecs[18] = '{3'b011, 12'hC02, 32'hFFFF_FFFF, 5'd0, 1'b1, 32'h0,         1'b0};
      vecs[19] = '{3'b001, 12'h341, 32'h20,        5'd0, 1'b1, 32'h0000_1000, 1'b0};
      vecs[20] = '{3'b010, 12'h341, 32'h0,         5'd0, 1'b1, 32'h20,        1'b0};
      vecs[21] = '{3'b111, 12'hC80, 32'h0,         5'd1, 1'b1, 32'h0,         1'b1};
      vecs[22] = '{3'b110, 12'hC82, 32'h0,         5'd0, 1'b1, 32'h0,         1'b0};

      rst_count("rst0");

      for (int k = 0; k < NV; k++) begin
         do_op(vecs[k].f3, vecs[k].adr, vecs[k].val, vecs[k].idx, d, il);
         if (vecs[k].chk) check($sformatf("vec%0d_data", k), d, vecs[k].exp_d);
         check($sformatf("vec%0d_illegal", k), {31'b0, il}, {31'b0, vecs[k].exp_i});
      end

      // Half writes: low-half write keeps the high half; then force a 64-bit wrap.
      do_op(3'b001, 12'hB80, 32'h5, 5'd1, d, il);
      check("mcycleh_initial", d, 32'h0);
      do_op(3'b001, 12'hB00, 32'h100, 5'd1, d, il);
      do_op(3'b010, 12'hB80, 32'h0, 5'd0, d, il);
      check("mcycleh_kept", d, 32'h5);
      do_op(3'b010, 12'hC80, 32'h0, 5'd0, d, il);
      check("cycleh_alias", d, 32'h5);
      do_op(3'b001, 12'hB80, 32'hFFFF_FFFF, 5'd1, d, il);
      do_op(3'b001, 12'hB00, 32'hFFFF_FFFF, 5'd1, d, il);
      do_op(3'b010, 12'hB00, 32'h0, 5'd0, d, il);
      check("mcycle_wrapped_small", {31'b0, (d < 32'd8)}, 32'd1);
      do_op(3'b010, 12'hB80, 32'h0, 5'd0, d, il);
      check("mcycleh_wrapped", d, 32'h0);

      // Retire on the same edge as the minstret commit: the write wins.
      @(negedge clk);
      drive(3'b001, 12'hB02, 32'h5, 5'd1);
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 retire = 1'b1;
      @(posedge clk);
      #1 retire = 1'b0;
      wait_rsp(d, il);
      check("minstret_old", d, 32'h0);
      @(posedge clk);
      #1;
      @(negedge clk) retire = 1'b1;
      @(negedge clk) retire = 1'b0;
      do_op(3'b010, 12'hB02, 32'h0, 5'd0, d, il);
      check("minstret_after_collision", d, 32'h6);
      @(negedge clk);
      drive(3'b010, 12'h340, 32'h0, 5'd0);
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      retire = 1'b1;
      @(posedge clk);
      #1 retire = 1'b0;
      wait_rsp(d, il);
      @(posedge clk);
      #1;
      do_op(3'b010, 12'hC02, 32'h0, 5'd0, d, il);
      check("instret_retire_during_op", d, 32'h7);

      // Backpressure: response held, new requests refused.
      @(negedge clk);
      drive(3'b010, 12'h340, 32'h0, 5'd0);
      req_valid = 1'b1;
      rsp_ready = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_rsp(d, il);
      check("bp_data", d, 32'h0000_BEFF);
      drive(3'b001, 12'h340, 32'h999, 5'd1);
      req_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("bp_valid_%0d", c), {31'b0, rsp_valid}, 32'd1);
         check($sformatf("bp_hold_%0d", c), rsp_data, 32'h0000_BEFF);
         check($sformatf("bp_ready_%0d", c), {31'b0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_released", {31'b0, rsp_valid}, 32'd0);
      do_op(3'b010, 12'h340, 32'h0, 5'd0, d, il);
      check("bp_no_accept", d, 32'h0000_BEFF);

      // Reset asserted while a response is pending.
      @(negedge clk);
      drive(3'b001, 12'h305, 32'h0000_0040, 5'd1);
      req_valid = 1'b1;
      rsp_ready = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_rsp(d, il);
      #1 rst_n = 1'b0;
      #1;
      check("midrsp_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("midrsp_req_ready", {31'b0, req_ready}, 32'd1);
      rst_count("rst1");
      do_op(3'b010, 12'h305, 32'h0, 5'd0, d, il);
      check("mtvec_reset", d, 32'h0);
      do_op(3'b010, 12'h340, 32'h0, 5'd0, d, il);
      check("mscratch_reset", d, 32'h0);
      do_op(3'b010, 12'hB82, 32'h0, 5'd0, d, il);
      check("minstreth_reset", d, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000");
      $fatal(1);
   end

endmodule
